// File: rtl/mioc_pkg.sv
// Shared types and helpers for the MIOC flop-cell driver.
// Optional glitch monitor in the top is enabled by MIOC_FLOP_DRIVER_GLITCH_CHK_EN.
package mioc_pkg;

  localparam int MIOC_CNT_W = 8;

  typedef enum logic [1:0] {
    MIOC_OP_WRITE = 2'b00,
    MIOC_OP_CLEAR = 2'b01,
    MIOC_OP_SET   = 2'b10,
    MIOC_OP_READ  = 2'b11
  } mioc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ASSERT,
    ST_SETTLE,
    ST_RESP
  } mioc_state_e;

  // Counter reload for a phase lasting cyc cycles; a zero length still lasts one cycle.
  function automatic logic [MIOC_CNT_W-1:0] mioc_load(input int cyc);
    if (cyc <= 1) return '0;
    return MIOC_CNT_W'(cyc - 1);
  endfunction

  // Response check: q and qb must disagree, and q must match what the command intended.
  function automatic logic mioc_check_fail(input mioc_op_e op, input logic data,
                                           input logic sq, input logic sqb);
    logic fail;
    fail = (sq == sqb);
    case (op)
      MIOC_OP_WRITE: fail = fail | (sq != data);
      MIOC_OP_SET:   fail = fail | (sq != 1'b1);
      MIOC_OP_CLEAR: fail = fail | (sq != 1'b0);
      default:       fail = fail;
    endcase
    return fail;
  endfunction

endpackage

// File: rtl/mioc_flop_driver_if.sv
// Command/response handshake between the control logic (master) and the flop driver (slave).
interface mioc_flop_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_q;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_q, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_q, rsp_err
  );
endinterface

// File: rtl/mioc_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module mioc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/mioc_flop_driver.sv
// Turns write/set/clear/read commands into timed pin waveforms for one MIOC flop cell
// and returns a checked readback. Glitch monitor: define MIOC_FLOP_DRIVER_GLITCH_CHK_EN.
module mioc_flop_driver
  import mioc_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int SYNC_CYC  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mioc_flop_driver_if.slave   bus,
  output logic                drv_in1,
  output logic                drv_in2,
  output logic                drv_in3,
  output logic                drv_in4,
  input  logic                mon_q,
  input  logic                mon_qb,
  output logic                err_sticky
);

  localparam logic [MIOC_CNT_W-1:0] SETUP_LD = mioc_load(SETUP_CYC);
  localparam logic [MIOC_CNT_W-1:0] PULSE_LD = mioc_load(PULSE_CYC);
  localparam logic [MIOC_CNT_W-1:0] HOLD_LD  = mioc_load(HOLD_CYC);
  localparam logic [MIOC_CNT_W-1:0] SYNC_LD  = mioc_load(SYNC_CYC);

  logic [1:0] mon_vec;
  logic [1:0] sync_vec;
  logic       sq;
  logic       sqb;

  assign mon_vec = {mon_qb, mon_q};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    mioc_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (mon_vec[gi]),
      .q     (sync_vec[gi])
    );
  end

  assign sq  = sync_vec[0];
  assign sqb = sync_vec[1];

  mioc_state_e           state_reg;
  logic [MIOC_CNT_W-1:0] cnt_reg;
  mioc_op_e              op_reg;
  logic                  data_reg;
  logic                  cmd_ready_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_q_reg;
  logic                  rsp_err_reg;
  logic                  in1_reg;
  logic                  in2_reg;
  logic                  in3_reg;
  logic                  in4_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      op_reg        <= MIOC_OP_READ;
      data_reg      <= 1'b0;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_q_reg     <= 1'b0;
      rsp_err_reg   <= 1'b0;
      in1_reg       <= 1'b1;
      in2_reg       <= 1'b0;
      in3_reg       <= 1'b0;
      in4_reg       <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_reg        <= mioc_op_e'(bus.cmd_op);
            data_reg      <= bus.cmd_data;
            cmd_ready_reg <= 1'b0;
            case (mioc_op_e'(bus.cmd_op))
              MIOC_OP_WRITE: begin
                state_reg <= ST_SETUP;
                cnt_reg   <= SETUP_LD;
                in3_reg   <= bus.cmd_data;
              end
              MIOC_OP_CLEAR: begin
                state_reg <= ST_ASSERT;
                cnt_reg   <= PULSE_LD;
                in1_reg   <= 1'b0;
              end
              MIOC_OP_SET: begin
                state_reg <= ST_ASSERT;
                cnt_reg   <= PULSE_LD;
                in4_reg   <= 1'b0;
              end
              default: begin
                // READ skips the pins entirely and answers from the synchroniser.
                state_reg     <= ST_RESP;
                cnt_reg       <= '0;
                rsp_valid_reg <= 1'b1;
                rsp_q_reg     <= sq;
                rsp_err_reg   <= mioc_check_fail(MIOC_OP_READ, 1'b0, sq, sqb);
              end
            endcase
          end
        end
        ST_SETUP: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_STROBE;
            cnt_reg   <= PULSE_LD;
            in2_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_STROBE: begin
          // The falling strobe at this exit is the flop's capture point.
          if (cnt_reg == '0) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= HOLD_LD;
            in2_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_SETTLE;
            cnt_reg   <= SYNC_LD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_ASSERT: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_SETTLE;
            cnt_reg   <= SYNC_LD;
            in1_reg   <= 1'b1;
            in4_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg     <= ST_RESP;
            cnt_reg       <= '0;
            rsp_valid_reg <= 1'b1;
            rsp_q_reg     <= sq;
            rsp_err_reg   <= mioc_check_fail(op_reg, data_reg, sq, sqb);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_q     = rsp_q_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign drv_in1       = in1_reg;
  assign drv_in2       = in2_reg;
  assign drv_in3       = in3_reg;
  assign drv_in4       = in4_reg;

`ifdef MIOC_FLOP_DRIVER_GLITCH_CHK_EN
  logic        sq_d_reg;
  mioc_state_e state_d_reg;
  logic [1:0]  warm_reg;
  logic        sticky_reg;
  logic        watched;

  // A change within one residency of IDLE/RESP is a change versus the entry value.
  assign watched = (state_reg == ST_IDLE) || (state_reg == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_d_reg    <= 1'b0;
      state_d_reg <= ST_IDLE;
      warm_reg    <= '0;
      sticky_reg  <= 1'b0;
    end else begin
      sq_d_reg    <= sq;
      state_d_reg <= state_reg;
      // The synchroniser is still filling for the first cycles after reset.
      if (warm_reg != 2'd3) warm_reg <= warm_reg + 1'b1;
      if (watched && (state_reg == state_d_reg) && (warm_reg == 2'd3) && (sq != sq_d_reg))
        sticky_reg <= 1'b1;
    end
  end

  assign err_sticky = sticky_reg;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mioc_flop_driver.sv
// Directed and randomized bench for mioc_flop_driver against a behavioural flop cell.
module tb_mioc_flop_driver;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC  = 1;
  localparam int SYNC_CYC  = 3;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  logic drv_in1, drv_in2, drv_in3, drv_in4;
  logic mon_q, mon_qb;
  logic err_sticky;

  int n_vec = 0;
  int n_err = 0;

  // Flop cell model: capture on strobe fall, async clear/set.
  logic flop_q = 1'b0;
  int   fault  = 0;      // 0 healthy, 1 q stuck at 0, 2 qb equals q
  logic glitch = 1'b0;
  logic ref_q;           // what the flop should hold, from the command history

  always @(negedge drv_in2) flop_q = drv_in3;
  always @(negedge drv_in1) flop_q = 1'b0;
  always @(negedge drv_in4) flop_q = 1'b1;

  assign mon_q  = ((fault == 1) ? 1'b0 : flop_q) ^ glitch;
  assign mon_qb = (fault == 1) ? 1'b1 : ((fault == 2) ? flop_q : ~flop_q);

  always #5 clk = ~clk;

  mioc_flop_driver_if bus ();

  mioc_flop_driver #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .SYNC_CYC  (SYNC_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .drv_in1    (drv_in1),
    .drv_in2    (drv_in2),
    .drv_in3    (drv_in3),
    .drv_in4    (drv_in4),
    .mon_q      (mon_q),
    .mon_qb     (mon_qb),
    .err_sticky (err_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] op);
    case (op)
      OP_WRITE: return SETUP_CYC + PULSE_CYC + HOLD_CYC + SYNC_CYC + 1;
      OP_READ:  return 1;
      default:  return PULSE_CYC + SYNC_CYC + 1;
    endcase
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full transaction: issue, observe pins until response, hold back-pressure, handshake.
  task automatic run_cmd(input logic [1:0] op, input logic d, input logic exp_q,
                         input logic exp_err, input int hold, input bit toggle);
    int lat, in2_hi, in1_lo, in4_lo, both_lo, busy_rdy, in3_bad;
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1; in2_hi = 0; in1_lo = 0; in4_lo = 0; both_lo = 0; busy_rdy = 0; in3_bad = 0;
    while (!bus.rsp_valid && lat < 64) begin
      if (drv_in2) in2_hi++;
      if (drv_in2 && drv_in3 !== d) in3_bad++;
      if (!drv_in1) in1_lo++;
      if (!drv_in4) in4_lo++;
      if (!drv_in1 && !drv_in4) both_lo++;
      if (bus.cmd_ready) busy_rdy++;
      @(posedge clk); #1;
      lat++;
    end
    $display("txn op=%0d data=%0b latency=%0d rsp_q=%0b rsp_err=%0b hold=%0d",
             op, d, lat, bus.rsp_q, bus.rsp_err, hold);
    chk("latency", lat, exp_latency(op));
    chk("rsp_q", bus.rsp_q, exp_q);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("in2_high_cycles", in2_hi, (op == OP_WRITE) ? PULSE_CYC : 0);
    chk("in1_low_cycles", in1_lo, (op == OP_CLEAR) ? PULSE_CYC : 0);
    chk("in4_low_cycles", in4_lo, (op == OP_SET) ? PULSE_CYC : 0);
    chk("in3_during_strobe", in3_bad, 0);
    chk("in1_in4_both_low", both_lo, 0);
    chk("cmd_ready_busy", busy_rdy, 0);
    for (int i = 0; i < hold; i++) begin
      if (toggle) glitch = ~glitch;
      @(posedge clk); #1;
      chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_rsp_q", bus.rsp_q, exp_q);
      chk("hold_rsp_err", bus.rsp_err, exp_err);
      chk("hold_cmd_ready", bus.cmd_ready, 1'b0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_after_ack", bus.rsp_valid, 1'b0);
    chk("cmd_ready_after_ack", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    logic [1:0] rop;
    logic rd;
    logic eq;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 1'b0;
    bus.rsp_ready = 1'b0;
    wait_cycles(3);
    chk("reset_in1", drv_in1, 1'b1);
    chk("reset_in2", drv_in2, 1'b0);
    chk("reset_in3", drv_in3, 1'b0);
    chk("reset_in4", drv_in4, 1'b1);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_q", bus.rsp_q, 1'b0);
    chk("reset_rsp_err", bus.rsp_err, 1'b0);
    chk("reset_err_sticky", err_sticky, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(4);
    chk("cmd_ready_after_reset", bus.cmd_ready, 1'b1);

    // Healthy WRITE 1, then SET / CLEAR back to back.
    run_cmd(OP_WRITE, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(OP_SET,   1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(OP_CLEAR, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Reset while the strobe is high.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_data  = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_cnt = 0;
    while (!drv_in2 && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("strobe_reached", drv_in2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in1", drv_in1, 1'b1);
    chk("midrst_in2", drv_in2, 1'b0);
    chk("midrst_in3", drv_in3, 1'b0);
    chk("midrst_in4", drv_in4, 1'b1);
    chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(4);
    chk("midrst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("midrst_no_rsp", bus.rsp_valid, 1'b0);

    run_cmd(OP_WRITE, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    ref_q = 1'b1;

    // Stuck-at-0 flop: WRITE 1 must report q=0 with an error.
    fault = 1;
    wait_cycles(4);
    run_cmd(OP_WRITE, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    // qb tracks q: READ must flag the error one cycle after accept.
    fault = 2;
    wait_cycles(4);
    run_cmd(OP_READ, 1'b0, ref_q, 1'b1, 0, 1'b0);
    fault = 0;
    wait_cycles(4);

    // Randomized commands against the command-history reference.
    for (int t = 0; t < 16; t++) begin
      rop = 2'($urandom_range(0, 3));
      rd  = 1'($urandom_range(0, 1));
      case (rop)
        OP_WRITE: eq = rd;
        OP_SET:   eq = 1'b1;
        OP_CLEAR: eq = 1'b0;
        default:  eq = ref_q;
      endcase
      run_cmd(rop, rd, eq, 1'b0, int'($urandom_range(0, 3)), 1'b0);
      ref_q = eq;
    end

    // Back-pressure for 10 cycles with mon_q toggling underneath.
    run_cmd(OP_READ, 1'b0, ref_q, 1'b0, 10, 1'b1);
`ifdef MIOC_FLOP_DRIVER_GLITCH_CHK_EN
    chk("err_sticky_glitch", err_sticky, 1'b1);
`else
    chk("err_sticky_tied", err_sticky, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mioc_flop_driver.md
Name: mioc_flop_driver

Overview:
- Command-driven driver for one external MIOC flop cell's pin set (in1 clear_n, in2 strobe, in3 data, in4 set_n). Flop captures in3 on the falling edge of in2.
- Turns write/set/clear/read requests into correctly timed pin waveforms.
- Reads the flop's q/qb back through a synchroniser and returns a checked response.
- Sits between the control logic and the flop cell; it is the initiator side of the flop's pin interface.

Parameters:
- SETUP_CYC, 2, cycles in3 is stable before in2 rises (1..255; 0 treated as 1)
- PULSE_CYC, 2, cycles in2 is high, or in1/in4 is low (1..255; 0 treated as 1)
- HOLD_CYC, 1, cycles in3 is held after in2 falls (1..255; 0 treated as 1)
- SYNC_CYC, 3, settle cycles before checking q/qb (>=2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 WRITE, 01 CLEAR, 10 SET, 11 READ
- cmd_data  in  1  bit to write (WRITE only)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response accepted
- rsp_q  out  1  synchronised q
- rsp_err  out  1  check failure
- drv_in1  out  1  to flop in1 (clear_n)
- drv_in2  out  1  to flop in2 (strobe)
- drv_in3  out  1  to flop in3 (data)
- drv_in4  out  1  to flop in4 (set_n)
- mon_q  in  1  flop q (asynchronous)
- mon_qb  in  1  flop qb (asynchronous)
- err_sticky  out  1  glitch flag (optional feature)

Behaviour:
- Reset (async, immediate, also mid-operation):
  - drv_in1=1, drv_in2=0, drv_in3=0, drv_in4=1.
  - rsp_valid=0, rsp_q=0, rsp_err=0, err_sticky=0.
  - FSM returns to IDLE; any in-flight command is abandoned and no response is issued.
- Synchroniser: mon_q and mon_qb each pass through a 2-flop synchroniser, giving sq and sqb.
- FSM states: IDLE, SETUP, STROBE, HOLD, ASSERT, SETTLE, RESP. One 8-bit down-counter is loaded on each state entry.
- IDLE: cmd_ready=1. A command is accepted when cmd_valid && cmd_ready. Op and data are latched.
  - WRITE -> SETUP
  - CLEAR/SET -> ASSERT
  - READ -> RESP
- SETUP: drv_in3=data, drv_in2=0, for SETUP_CYC cycles -> STROBE.
- STROBE: drv_in2=1 for PULSE_CYC cycles -> HOLD. The flop captures on the STROBE-to-HOLD transition.
- HOLD: drv_in2=0, drv_in3 held, for HOLD_CYC cycles -> SETTLE.
- ASSERT: drv_in1=0 (CLEAR) or drv_in4=0 (SET) for PULSE_CYC cycles -> SETTLE. drv_in1 and drv_in4 are never low together.
- SETTLE: all pins idle except drv_in3, which keeps its last value. Lasts SYNC_CYC cycles -> RESP.
- Entering RESP: rsp_q is loaded with sq. rsp_err is set if any of:
  - sq == sqb
  - WRITE and sq != data
  - SET and sq != 1
  - CLEAR and sq != 0
  - READ checks only sq == sqb.
- RESP: rsp_valid=1. rsp_q and rsp_err are held stable until rsp_ready. On rsp_ready -> IDLE, with rsp_valid=0 on the next cycle.
- Latency from accept to rsp_valid:
  - WRITE: SETUP_CYC+PULSE_CYC+HOLD_CYC+SYNC_CYC+1
  - SET/CLEAR: PULSE_CYC+SYNC_CYC+1
  - READ: 1
- Commands are not queued: cmd_ready stays 0 from accept until the response handshake completes.

Optional Feature:
- Macro: MIOC_FLOP_DRIVER_GLITCH_CHK_EN.
- Defined: in IDLE and RESP, any change of sq versus its value on entry to that state sets err_sticky=1. It clears only on reset.
- Undefined: err_sticky is tied to 0 and no monitor logic is built.

Decomposition:
- Package mioc_pkg holds:
  - cmd_op encodings MIOC_OP_WRITE/CLEAR/SET/READ
  - FSM state enum
  - counter width constant MIOC_CNT_W=8
- One natural sub-module: mioc_sync2, a 2-flop synchroniser instantiated for mon_q and mon_qb.

Test Plan:
- Reset mid-STROBE: assert rst_n=0 during STROBE -> pins go to 1/0/0/1 immediately; rsp_valid=0; cmd_ready=1 after release.
- WRITE 1 with the flop model sampling on the in2 fall, defaults -> drv_in2 high exactly 2 cycles; rsp_valid 9 cycles after accept; rsp_q=1, rsp_err=0.
- SET then CLEAR back to back -> drv_in4 low 2 cycles, then drv_in1 low 2 cycles; responses rsp_q=1, then rsp_q=0, both with rsp_err=0.
- Faulty model stuck at 0, WRITE 1 -> rsp_q=0, rsp_err=1.
- Faulty model with qb==q, READ -> rsp_err=1 one cycle after accept.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_q and rsp_err stay stable and cmd_ready=0. With the macro defined, toggling mon_q in this window -> err_sticky=1.
